qdiv_seq: RTL and testbench

//  Sequential signed fixed-point divider, companion to qmult: o_result = (a / b) in QN.Q format.

---
 rtl/qdiv_seq.sv | 176 +++++++++++++++++
 tb/tb_qdiv_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/qdiv_seq.sv
// qdiv_seq: sequential signed fixed-point divider, o_result = a / b in QN.Q format.
// Restoring shift/subtract core, one quotient bit per clock. The quotient is
// truncated toward zero, saturated symmetrically to +/-(2^(N-1)-1), and a zero
// divisor yields a saturated result that follows the sign of the dividend.
//
// Ports
//   clk       in   1  clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   start     in   1  request, sampled only while busy=0
//   a         in   N  dividend, signed QN.Q, captured on accepted start
//   b         in   N  divisor, signed QN.Q, captured on accepted start
//   busy      out  1  operation in flight (CALC or FIN)
//   done      out  1  one-cycle pulse, o_result/ovr/dbz updated
//   o_result  out  N  signed quotient QN.Q, held until the next done
//   ovr       out  1  result saturated, held with o_result
//   dbz       out  1  divide by zero, held with o_result
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start, outputs hold the last result
// CALC   | N+Q restoring iterations, one quotient bit per cycle
// FIN    | sign fix / saturation, outputs registered, done pulsed
module qdiv_seq #(
  parameter int Q = 18,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] o_result,
  output logic         ovr,
  output logic         dbz
);

  localparam int W  = N + Q;
  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [N-1:0]  MAX_POS  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  MAX_NEG  = {1'b1, {(N-2){1'b0}}, 1'b1};
  localparam logic [W-1:0]  MAX_WIDE = {{Q{1'b0}}, MAX_POS};

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Shared dividend/quotient register: dividend bits leave at the MSB while
  // quotient bits enter at the LSB.
  logic [W-1:0]  dq_q, dq_d;
  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  bmag_q, bmag_d;
  logic          sign_q, sign_d;
  logic          aneg_q, aneg_d;
  logic [N-1:0]  res_q, res_d;
  logic          ovr_q, ovr_d;
  logic          dbz_q, dbz_d;
  logic          done_q, done_d;

  logic [N-1:0] a_mag, b_mag;
  logic [N:0]   rem_sh;
  logic [N-1:0] qm_lo, qm_neg;

  // N-bit unsigned magnitudes, so |-2^(N-1)| = 2^(N-1) is representable.
  assign a_mag  = a[N-1] ? (~a + 1'b1) : a;
  assign b_mag  = b[N-1] ? (~b + 1'b1) : b;
  assign rem_sh = {rem_q[N-1:0], dq_q[W-1]};
  assign qm_lo  = dq_q[N-1:0];
  assign qm_neg = ~qm_lo + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    bmag_d  = bmag_q;
    sign_d  = sign_q;
    aneg_d  = aneg_q;
    res_d   = res_q;
    ovr_d   = ovr_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d  = a[N-1] ^ b[N-1];
          aneg_d  = a[N-1];
          bmag_d  = b_mag;
          dq_d    = {a_mag, {Q{1'b0}}};
          rem_d   = '0;
          cnt_d   = CNT_LAST;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        // Divisor zero just yields all-ones here; FIN overrides the result.
        if (rem_sh >= {1'b0, bmag_q}) begin
          rem_d = rem_sh - {1'b0, bmag_q};
          dq_d  = {dq_q[W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          dq_d  = {dq_q[W-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_FIN: begin
        if (bmag_q == '0) begin
          res_d = aneg_q ? MAX_NEG : MAX_POS;
          ovr_d = 1'b1;
          dbz_d = 1'b1;
        end else if (dq_q > MAX_WIDE) begin
          // Exact -2^(N-1) also lands here: saturation is symmetric.
          res_d = sign_q ? MAX_NEG : MAX_POS;
          ovr_d = 1'b1;
          dbz_d = 1'b0;
        end else begin
          // qm == 0 negates to 0, so no negative zero can appear.
          res_d = sign_q ? qm_neg : qm_lo;
          ovr_d = 1'b0;
          dbz_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      bmag_q  <= '0;
      sign_q  <= 1'b0;
      aneg_q  <= 1'b0;
      res_q   <= '0;
      ovr_q   <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      bmag_q  <= bmag_d;
      sign_q  <= sign_d;
      aneg_q  <= aneg_d;
      res_q   <= res_d;
      ovr_q   <= ovr_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == S_CALC) || (state_q == S_FIN);
  assign done     = done_q;
  assign o_result = res_q;
  assign ovr      = ovr_q;
  assign dbz      = dbz_q;

endmodule

// File: tb/tb_qdiv_seq.sv
// tb_qdiv_seq: directed vectors with hand-computed quotients for qdiv_seq,
// plus handshake checks (latency, back-to-back, held start, mid-op reset).
module tb_qdiv_seq;
  localparam int N = 32;
  localparam int Q = 18;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] o_result;
  logic         ovr;
  logic         dbz;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  qdiv_seq #(.Q(Q), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .o_result (o_result),
    .ovr      (ovr),
    .dbz      (dbz)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Called #1 after an edge; start is accepted on the next edge.
  task automatic launch(input logic [N-1:0] av, input logic [N-1:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Edges counted from the accepting edge; 100 means no done seen.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 100);
  endtask

  task automatic run_vec(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic [N-1:0] er, input logic eo, input logic ed);
    int lat;
    launch(av, bv);
    chk({tag, " busy"}, 64'(busy), 64'd1);
    wait_done(lat);
    chk({tag, " latency"}, 64'(lat), 64'd51);
    chk({tag, " result"}, 64'(o_result), 64'(er));
    chk({tag, " ovr"}, 64'(ovr), 64'(eo));
    chk({tag, " dbz"}, 64'(dbz), 64'(ed));
    chk({tag, " busy@done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int ndone;
    int first;
    int lat;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst result", 64'(o_result), 64'd0);
    chk("rst ovr", 64'(ovr), 64'd0);
    chk("rst dbz", 64'(dbz), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Consecutive run_vec calls restart in the done cycle (back-to-back).
    run_vec("3/1.5",      32'h000C0000, 32'h00060000, 32'h00080000, 1'b0, 1'b0);
    run_vec("-1/4",       32'hFFFC0000, 32'h00100000, 32'hFFFF0000, 1'b0, 1'b0);
    run_vec("0.5/-1.5",   32'h00020000, 32'hFFFA0000, 32'hFFFEAAAB, 1'b0, 1'b0);
    run_vec("tiny/2",     32'h00000001, 32'h00080000, 32'h00000000, 1'b0, 1'b0);
    run_vec("-tiny/2",    32'hFFFFFFFF, 32'h00080000, 32'h00000000, 1'b0, 1'b0);
    run_vec("5/0",        32'h00140000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b1);
    run_vec("-5/0",       32'hFFEC0000, 32'h00000000, 32'h80000001, 1'b1, 1'b1);
    run_vec("0/0",        32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b1);
    run_vec("max/1",      32'h7FFFFFFF, 32'h00040000, 32'h7FFFFFFF, 1'b0, 1'b0);
    run_vec("max/lsb",    32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0);
    run_vec("min/-1",     32'h80000000, 32'hFFFC0000, 32'h7FFFFFFF, 1'b1, 1'b0);
    run_vec("min/1",      32'h80000000, 32'h00040000, 32'h80000001, 1'b1, 1'b0);

    // Outputs hold while idle.
    repeat (5) @(posedge clk);
    #1;
    chk("hold result", 64'(o_result), 64'h80000001);
    chk("hold ovr", 64'(ovr), 64'd1);
    chk("hold done", 64'(done), 64'd0);

    // Start held and operands scrambled while busy: one done, original operands.
    start = 1'b1;
    a     = 32'h000C0000;
    b     = 32'h00060000;
    @(posedge clk);
    #1;
    ndone = 0;
    first = 0;
    for (int i = 1; i <= 100; i++) begin
      if (i < 40) begin
        a = $urandom;
        b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (ndone == 1) first = i;
      end
    end
    chk("held start dones", 64'(ndone), 64'd1);
    chk("held start latency", 64'(first), 64'd51);
    chk("held start result", 64'(o_result), 64'h00080000);
    chk("held start ovr", 64'(ovr), 64'd0);

    // Mid-operation reset: no done, outputs back to reset values.
    run_vec("pre-rst", 32'hFFFC0000, 32'h00100000, 32'hFFFF0000, 1'b0, 1'b0);
    launch(32'h7FFFFFFF, 32'h00000001);
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst result", 64'(o_result), 64'd0);
    chk("midrst ovr", 64'(ovr), 64'd0);
    chk("midrst dbz", 64'(dbz), 64'd0);
    #5;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("midrst no done", 64'(ndone), 64'd0);
    chk("midrst result held", 64'(o_result), 64'd0);

    run_vec("post-rst", 32'h000C0000, 32'h00060000, 32'h00080000, 1'b0, 1'b0);
    wait_done(lat);
    chk("post-rst no extra done", 64'(lat), 64'd100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
